// File: rtl/forward_select_unit_pkg.sv
// Shared constants and helpers for the Execute-stage operand forwarding unit.
package forward_select_unit_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;
  // forwardSel value meaning "take the register-file operand"
  localparam int unsigned FWD_SEL_RF = 0;

  // Select width: one code for the register file plus one per tracked stage
  function automatic int unsigned selWidth(input int unsigned numStages);
    return $clog2(numStages + 1);
  endfunction

endpackage

// File: rtl/fwd_port_select.sv
// One ALU source port: youngest-stage priority match and operand mux.
module fwd_port_select
  import forward_select_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned SELW       = selWidth(NUM_STAGES)
) (
  input  logic [REG_AW-1:0]            srcAddr,
  input  logic [XLEN-1:0]              readData,
  input  logic [NUM_STAGES-1:0]        stageVld,
  input  logic [NUM_STAGES*REG_AW-1:0] stageRd,
  input  logic [NUM_STAGES*XLEN-1:0]   stageData,
  output logic [SELW-1:0]              sel_c,
  output logic [XLEN-1:0]              operand_c,
  output logic                         match0_c
);

  logic [NUM_STAGES-1:0] match;

  // Per-stage address match; x0 is hard-wired zero and never forwarded
  always_comb begin
    match = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      match[s] = stageVld[s] && (stageRd[s*REG_AW +: REG_AW] == srcAddr) && (srcAddr != '0);
    end
  end

  // Priority encode: scan oldest to youngest so the youngest match overwrites
  always_comb begin
    sel_c = SELW'(FWD_SEL_RF);
    for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
      if (match[s]) sel_c = SELW'(s + 1);
    end
  end

  // Operand mux driven by the select code
  always_comb begin
    operand_c = readData;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      if (sel_c == SELW'(s + 1)) operand_c = stageData[s*XLEN +: XLEN];
    end
  end

  assign match0_c = match[0];

endmodule

// File: rtl/forward_select_unit.sv
// Operand forwarding and load-use hazard unit for the Execute stage.
module forward_select_unit
  import forward_select_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          advance,
  input  logic                                          flush,
  input  logic [REG_AW-1:0]                             issueRd,
  input  logic                                          issueRegWrite,
  input  logic                                          issueIsLoad,
  input  logic [NUM_PORTS*REG_AW-1:0]                   srcAddr,
  input  logic [NUM_PORTS*XLEN-1:0]                     readData,
  input  logic [NUM_STAGES*XLEN-1:0]                    stageData,
  output logic [NUM_PORTS*XLEN-1:0]                     operandOut,
  output logic [NUM_PORTS*selWidth(NUM_STAGES)-1:0]     forwardSel,
  output logic                                          loadUseStall,
  output logic [CNT_W-1:0]                              stallCount
);

  localparam int unsigned SELW = selWidth(NUM_STAGES);

  logic [NUM_STAGES-1:0]        vldQ;
  logic [NUM_STAGES*REG_AW-1:0] rdQ;
  // Only a load in the newest stage can stall, so older stages drop the flag
  logic                         ldQ;
  logic [NUM_PORTS-1:0]         portMatch0;

  // Per-port match and mux instances
  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    fwd_port_select #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES),
      .REG_AW     (REG_AW),
      .SELW       (SELW)
    ) uSel (
      .srcAddr   (srcAddr[p*REG_AW +: REG_AW]),
      .readData  (readData[p*XLEN +: XLEN]),
      .stageVld  (vldQ),
      .stageRd   (rdQ),
      .stageData (stageData),
      .sel_c     (forwardSel[p*SELW +: SELW]),
      .operand_c (operandOut[p*XLEN +: XLEN]),
      .match0_c  (portMatch0[p])
    );
  end

  // Any port depending on a load still in stage 0 must wait one cycle
  assign loadUseStall = ldQ & (|portMatch0);

  // Destination tracking shift register; a stall shifts in a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldQ <= '0;
      rdQ  <= '0;
      ldQ  <= 1'b0;
    end else if (flush) begin
      vldQ <= '0;
    end else if (advance) begin
      for (int s = 1; s < int'(NUM_STAGES); s++) begin
        vldQ[s]                  <= vldQ[s-1];
        rdQ[s*REG_AW +: REG_AW] <= rdQ[(s-1)*REG_AW +: REG_AW];
      end
      vldQ[0]          <= issueRegWrite & ~loadUseStall & (issueRd != '0);
      rdQ[REG_AW-1:0]  <= issueRd;
      ldQ              <= issueIsLoad;
    end
  end

  // Saturating count of stall cycles that actually held the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (loadUseStall && advance && !flush && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_forward_select_unit.sv
// Scenario bench for forward_select_unit (2 ports, 2 stages, 4-bit stall counter).
module tb_forward_select_unit;

  localparam logic [31:0] RF0 = 32'h0BAD_0000;
  localparam logic [31:0] RF1 = 32'h0BAD_0001;
  localparam logic [31:0] SD0 = 32'hA5A5_0001;
  localparam logic [31:0] SD1 = 32'h5A5A_0002;

  logic        clk;
  logic        rst_n;
  logic        advance;
  logic        flush;
  logic [4:0]  issueRd;
  logic        issueRegWrite;
  logic        issueIsLoad;
  logic [9:0]  srcAddr;
  logic [63:0] readData;
  logic [63:0] stageData;
  logic [63:0] operandOut;
  logic [3:0]  forwardSel;
  logic        loadUseStall;
  logic [3:0]  stallCount;

  forward_select_unit #(
    .XLEN       (32),
    .NUM_PORTS  (2),
    .NUM_STAGES (2),
    .REG_AW     (5),
    .CNT_W      (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance       (advance),
    .flush         (flush),
    .issueRd       (issueRd),
    .issueRegWrite (issueRegWrite),
    .issueIsLoad   (issueIsLoad),
    .srcAddr       (srcAddr),
    .readData      (readData),
    .stageData     (stageData),
    .operandOut    (operandOut),
    .forwardSel    (forwardSel),
    .loadUseStall  (loadUseStall),
    .stallCount    (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {sel1, sel0, op1, op0, stall, count}
  wire [72:0] obs = {forwardSel, operandOut, loadUseStall, stallCount};

  typedef struct {
    string       name;
    logic [72:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passCount  = 0;
  int   checkCount = 0;
  int   expCnt;

  function automatic logic [72:0] pk(input logic [1:0] s1, input logic [1:0] s0,
                                     input logic [31:0] o1, input logic [31:0] o0,
                                     input logic st, input logic [3:0] c);
    return {s1, s0, o1, o0, st, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setIssue(input logic [4:0] rd, input logic we, input logic ld);
    issueRd       = rd;
    issueRegWrite = we;
    issueIsLoad   = ld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    srcAddr = {5'd3, 5'd5};
    rst_n   = 1'b1;
    sb.push_back('{"reset_idle", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
  endtask

  task automatic test_forward_basic();
    setIssue(5'd5, 1'b1, 1'b0);
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd3, 5'd5};
    sb.push_back('{"fwd_stage0", pk(2'd0, 2'd1, RF1, SD0, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    sb.push_back('{"fwd_stage1", pk(2'd0, 2'd2, RF1, SD1, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    sb.push_back('{"fwd_retired", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
  endtask

  task automatic test_youngest();
    setIssue(5'd7, 1'b1, 1'b0);
    tick();
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd7, 5'd7};
    sb.push_back('{"youngest_wins", pk(2'd1, 2'd1, SD0, SD0, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    setIssue(5'd8, 1'b1, 1'b0);
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd8, 5'd7};
    sb.push_back('{"ports_split", pk(2'd1, 2'd2, SD0, SD1, 1'b0, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    tick();
  endtask

  task automatic test_load_use();
    setIssue(5'd9, 1'b1, 1'b1);
    srcAddr = {5'd3, 5'd3};
    tick();
    setIssue(5'd10, 1'b1, 1'b0);
    srcAddr = {5'd9, 5'd3};
    sb.push_back('{"lu_stall", pk(2'd1, 2'd0, SD0, RF0, 1'b1, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    advance = 1'b0;
    tick();
    sb.push_back('{"lu_freeze", pk(2'd1, 2'd0, SD0, RF0, 1'b1, 4'd0)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    advance = 1'b1;
    tick();
    srcAddr = {5'd9, 5'd10};
    sb.push_back('{"lu_bubble", pk(2'd2, 2'd0, SD1, RF0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    sb.push_back('{"lu_resume", pk(2'd0, 2'd1, RF1, SD0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    tick();
  endtask

  task automatic test_x0_flush();
    setIssue(5'd0, 1'b1, 1'b0);
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd0, 5'd0};
    sb.push_back('{"x0_nofwd", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    setIssue(5'd12, 1'b1, 1'b0);
    tick();
    setIssue(5'd13, 1'b1, 1'b0);
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd12, 5'd13};
    sb.push_back('{"flush_pre", pk(2'd2, 2'd1, SD1, SD0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    flush = 1'b1;
    setIssue(5'd14, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd12, 5'd14};
    sb.push_back('{"flush_post", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    setIssue(5'd9, 1'b1, 1'b1);
    srcAddr = {5'd3, 5'd3};
    tick();
    setIssue(5'd0, 1'b0, 1'b0);
    srcAddr = {5'd9, 5'd9};
    flush = 1'b1;
    sb.push_back('{"flush_stall", pk(2'd1, 2'd1, SD0, SD0, 1'b1, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    tick();
    flush = 1'b0;
    sb.push_back('{"flush_nocount", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd1)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
  endtask

  task automatic test_saturation_async_reset();
    expCnt = 1;
    for (int i = 0; i < 16; i++) begin
      setIssue(5'd9, 1'b1, 1'b1);
      srcAddr = {5'd3, 5'd3};
      tick();
      srcAddr = {5'd9, 5'd9};
      sb.push_back('{"sat_stall", pk(2'd1, 2'd1, SD0, SD0, 1'b1, 4'(expCnt))});
      #2; e = sb.pop_front(); checkCount++;
      if (obs !== e.v) $display("FAIL %s[%0d]: got %h want %h", e.name, i, obs, e.v); else passCount++;
      tick();
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
    end
    srcAddr = {5'd3, 5'd3};
    tick();
    srcAddr = {5'd9, 5'd9};
    sb.push_back('{"sat_hold", pk(2'd1, 2'd1, SD0, SD0, 1'b1, 4'd15)});
    #2; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    #1 rst_n = 1'b0;
    sb.push_back('{"async_rst", pk(2'd0, 2'd0, RF1, RF0, 1'b0, 4'd0)});
    #1; e = sb.pop_front(); checkCount++;
    if (obs !== e.v) $display("FAIL %s: got %h want %h", e.name, obs, e.v); else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    advance       = 1'b1;
    flush         = 1'b0;
    issueRd       = '0;
    issueRegWrite = 1'b0;
    issueIsLoad   = 1'b0;
    srcAddr       = '0;
    readData      = {RF1, RF0};
    stageData     = {SD1, SD0};
    @(negedge clk);
    test_reset();
    test_forward_basic();
    test_youngest();
    test_load_use();
    test_x0_flush();
    test_saturation_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
